// File: rtl/dffr_buffer_pkg.sv
// Shared types and constants for the pin-input buffer and its period/high-time meter.
package dffr_buffer_pkg;

  localparam int unsigned NUM_CH = 8;

  // Channel order on the sync_out / rise_pulse buses.
  localparam int unsigned CH_CLK_P     = 0;
  localparam int unsigned CH_CLK_SHORT = 1;
  localparam int unsigned CH_CLK_D     = 2;
  localparam int unsigned CH_CLK_DAC   = 3;
  localparam int unsigned CH_CLK_DAC_P = 4;
  localparam int unsigned CH_CLK_DAC_D = 5;
  localparam int unsigned CH_RST       = 6;
  localparam int unsigned CH_STIM      = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } meas_state_e;

endpackage

// File: rtl/sync_edge_cell.sv
// One channel: multi-flop synchronizer plus registered rising-edge detector.
module sync_edge_cell #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic sync_o,
  output logic dly_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   dly_q;
  logic                   rise_q;

  // Shift the pin through the chain; dly_q is sync_o one cycle late, so rise_q and dly_q
  // are time-aligned and the meter can measure high time from dly_o without skew.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
      dly_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
      dly_q   <= chain_q[SYNC_STAGES-1];
      rise_q  <= chain_q[SYNC_STAGES-1] & ~dly_q;
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign dly_o  = dly_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/dffr_buffer_in.sv
// Synchronizes eight asynchronous pins and measures high time and period of one selected channel.
module dffr_buffer_in
  import dffr_buffer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_in_500MHz,
  input  logic              reset,
  input  logic              in_clk_p,
  input  logic              in_clk_short,
  input  logic              in_clk_d,
  input  logic              in_clk_dac,
  input  logic              in_clk_dac_p,
  input  logic              in_clk_dac_d,
  input  logic              in_RST,
  input  logic              in_STIM,
  input  logic [2:0]        sel,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [CNT_W-1:0]  meas_high,
  output logic [CNT_W-1:0]  meas_period,
  output logic              meas_valid,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [NUM_CH-1:0] pins;
  logic [NUM_CH-1:0] dly;

  meas_state_e      state_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] meas_high_q;
  logic [CNT_W-1:0] meas_period_q;
  logic             meas_valid_q;
  logic             timeout_q;
  logic [2:0]       sel_q;

  logic sel_chg;
  logic rise_sel;
  logic dly_sel;
  logic cnt_sat;

  // Gather the named pins into channel order.
  always_comb begin
    pins               = '0;
    pins[CH_CLK_P]     = in_clk_p;
    pins[CH_CLK_SHORT] = in_clk_short;
    pins[CH_CLK_D]     = in_clk_d;
    pins[CH_CLK_DAC]   = in_clk_dac;
    pins[CH_CLK_DAC_P] = in_clk_dac_p;
    pins[CH_CLK_DAC_D] = in_clk_dac_d;
    pins[CH_RST]       = in_RST;
    pins[CH_STIM]      = in_STIM;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_edge_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk_i (clk_in_500MHz),
      .rst_i (reset),
      .pin_i (pins[g]),
      .sync_o(sync_out[g]),
      .dly_o (dly[g]),
      .rise_o(rise_pulse[g])
    );
  end

  assign sel_chg  = (sel != sel_q);
  assign rise_sel = rise_pulse[sel];
  assign dly_sel  = dly[sel];
  assign cnt_sat  = (high_cnt_q == CntMax) || (period_cnt_q == CntMax);

  // Measurement FSM with counters and registered results. High time is tracked against the
  // delayed level so that both edges carry the same pipeline latency and it cancels out.
  always_ff @(posedge clk_in_500MHz) begin
    if (reset) begin
      state_q       <= IDLE;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      meas_high_q   <= '0;
      meas_period_q <= '0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      // Track sel through reset so a static sel does not look like a change afterwards.
      sel_q         <= sel;
    end else begin
      sel_q        <= sel;
      meas_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (!sel_chg && rise_sel) begin
            state_q      <= HIGH;
            high_cnt_q   <= CntOne;
            period_cnt_q <= CntOne;
          end
        end
        HIGH: begin
          if (sel_chg) begin
            state_q <= WAIT_RISE;
          end else if (cnt_sat) begin
            timeout_q <= 1'b1;
            state_q   <= WAIT_RISE;
          end else if (!dly_sel) begin
            state_q      <= LOW;
            period_cnt_q <= period_cnt_q + CntOne;
          end else begin
            high_cnt_q   <= high_cnt_q + CntOne;
            period_cnt_q <= period_cnt_q + CntOne;
          end
        end
        LOW: begin
          if (sel_chg) begin
            state_q <= WAIT_RISE;
          end else if (rise_sel) begin
            meas_high_q   <= high_cnt_q;
            meas_period_q <= period_cnt_q;
            meas_valid_q  <= 1'b1;
            timeout_q     <= 1'b0;
            high_cnt_q    <= CntOne;
            period_cnt_q  <= CntOne;
            state_q       <= HIGH;
          end else if (period_cnt_q == CntMax) begin
            timeout_q <= 1'b1;
            state_q   <= WAIT_RISE;
          end else begin
            period_cnt_q <= period_cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign meas_high   = meas_high_q;
  assign meas_period = meas_period_q;
  assign meas_valid  = meas_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_dffr_buffer_in.sv
// Scoreboard bench for dffr_buffer_in: directed pin waveforms, expected strobes queued at the
// stimulus side and popped by an independent monitor.
module tb_dffr_buffer_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pins;
  logic [2:0]  sel;
  logic [7:0]  sync_out;
  logic [7:0]  rise_pulse;
  logic [15:0] meas_high;
  logic [15:0] meas_period;
  logic        meas_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] per;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #1 clk = ~clk;

  dffr_buffer_in #(
    .SYNC_STAGES(3),
    .CNT_W      (16)
  ) dut (
    .clk_in_500MHz(clk),
    .reset        (reset),
    .in_clk_p     (pins[0]),
    .in_clk_short (pins[1]),
    .in_clk_d     (pins[2]),
    .in_clk_dac   (pins[3]),
    .in_clk_dac_p (pins[4]),
    .in_clk_dac_d (pins[5]),
    .in_RST       (pins[6]),
    .in_STIM      (pins[7]),
    .sel          (sel),
    .sync_out     (sync_out),
    .rise_pulse   (rise_pulse),
    .meas_high    (meas_high),
    .meas_period  (meas_period),
    .meas_valid   (meas_valid),
    .timeout      (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int h, input int p);
    exp_t e;
    e.hi  = 16'(h);
    e.per = 16'(p);
    e.to  = 1'b0;
    exp_q.push_back(e);
  endtask

  // n full periods on channel ch; every rise after the first closes a measurement.
  task automatic toggle(input int ch, input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      pins[ch] = 1'b1;
      if (k > 0) push(h, h + l);
      repeat (h) @(negedge clk);
      pins[ch] = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas_valid: got high=%0d period=%0d expected no strobe at %0t",
                 meas_high, meas_period, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("meas_high", 32'(meas_high), 32'(mon_e.hi));
        chk("meas_period", 32'(meas_period), 32'(mon_e.per));
        chk("timeout_at_valid", 32'(timeout), 32'(mon_e.to));
      end
    end
  end

  int          hv[8] = '{1, 2, 3, 1, 2, 2, 4, 1};
  int          lv[8] = '{1, 1, 2, 3, 3, 5, 2, 4};
  logic [7:0]  hist[5];
  logic [7:0]  p;
  logic [7:0]  exp_rise;

  initial begin
    reset = 1'b1;
    pins  = '1;
    sel   = 3'd0;

    // Reset holds everything at zero even with all pins high.
    repeat (4) @(negedge clk);
    chk("rst_sync_out", 32'(sync_out), 32'd0);
    chk("rst_rise_pulse", 32'(rise_pulse), 32'd0);
    chk("rst_meas_high", 32'(meas_high), 32'd0);
    chk("rst_meas_period", 32'(meas_period), 32'd0);
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    pins = '0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Channel 0, 4 high / 6 low.
    toggle(0, 4, 6, 5);
    repeat (20) @(negedge clk);
    chk("ch0_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("ch0_timeout", 32'(timeout), 32'd0);

    // Single-cycle STIM pulse: sync_out after 3 cycles, rise_pulse after 4 for one cycle.
    pins[7] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk($sformatf("stim_sync_%0d", i), 32'(sync_out[7]), 32'(i == 3));
      chk($sformatf("stim_rise_%0d", i), 32'(rise_pulse[7]), 32'(i == 4));
      if (i == 1) pins[7] = 1'b0;
    end

    // Abort mid-HIGH by moving sel from 0 to 3; channel 0 strobes must never appear.
    do_reset(2);
    repeat (3) @(negedge clk);
    pins[0] = 1'b1;
    repeat (7) @(negedge clk);
    sel = 3'd3;
    @(negedge clk);
    pins[0] = 1'b0;
    repeat (4) @(negedge clk);
    pins[0] = 1'b1;
    repeat (3) @(negedge clk);
    pins[0] = 1'b0;
    repeat (6) @(negedge clk);
    toggle(3, 3, 4, 4);
    repeat (20) @(negedge clk);
    chk("sel_abort_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in LOW: restart via sel bounce so results from above are still held.
    sel = 3'd4;
    @(negedge clk);
    sel = 3'd3;
    repeat (3) @(negedge clk);
    chk("held_meas_high", 32'(meas_high), 32'd3);
    pins[3] = 1'b1;
    repeat (3) @(negedge clk);
    pins[3] = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_sync_out", 32'(sync_out), 32'd0);
    chk("midrst_rise_pulse", 32'(rise_pulse), 32'd0);
    chk("midrst_meas_high", 32'(meas_high), 32'd0);
    chk("midrst_meas_period", 32'(meas_period), 32'd0);
    chk("midrst_meas_valid", 32'(meas_valid), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    toggle(3, 3, 4, 3);
    repeat (20) @(negedge clk);
    chk("midrst_queue_drained", 32'(exp_q.size()), 32'd0);

    // All channels at different rates, measuring channel 5.
    sel = 3'd5;
    do_reset(2);
    repeat (6) @(negedge clk);
    for (int k = 0; k < 5; k++) hist[k] = '0;
    for (int n = 0; n < 120; n++) begin
      chk($sformatf("all_sync_%0d", n), 32'(sync_out), 32'(hist[2]));
      exp_rise = hist[3] & ~hist[4];
      chk($sformatf("all_rise_%0d", n), 32'(rise_pulse), 32'(exp_rise));
      for (int c = 0; c < 8; c++) p[c] = ((n % (hv[c] + lv[c])) < hv[c]);
      if (p[5] && !hist[0][5] && n > 0) push(hv[5], hv[5] + lv[5]);
      pins = p;
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = p;
      @(negedge clk);
    end
    pins = '0;
    repeat (20) @(negedge clk);
    chk("all_queue_drained", 32'(exp_q.size()), 32'd0);

    // Channel 2 stuck high saturates the counters; results hold until a good measurement.
    sel = 3'd2;
    repeat (2) @(negedge clk);
    pins[2] = 1'b1;
    repeat (60000) @(negedge clk);
    chk("sat_timeout_early", 32'(timeout), 32'd0);
    repeat (10000) @(negedge clk);
    chk("sat_timeout_set", 32'(timeout), 32'd1);
    chk("sat_hold_high", 32'(meas_high), 32'd2);
    chk("sat_hold_period", 32'(meas_period), 32'd7);
    pins[2] = 1'b0;
    repeat (10) @(negedge clk);
    toggle(2, 5, 5, 4);
    repeat (20) @(negedge clk);
    chk("sat_timeout_cleared", 32'(timeout), 32'd0);
    chk("sat_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dffr_buffer_in.md
DFFR_BUFFER_IN -- requirements
Module: dffr_buffer_in

Interface
REQ-001 Parameter: SYNC_STAGES, 3, number of synchronizer flops per input (minimum 2).
REQ-002 Parameter: CNT_W, 16, width of measurement counters.
REQ-003 Port: clk_in_500MHz  in  1  sole clock; all logic SHALL be in this single domain.
REQ-004 Port: reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk_in_500MHz.
REQ-005 Port: in_clk_p, in_clk_short, in_clk_d, in_clk_dac, in_clk_dac_p, in_clk_dac_d, in_RST, in_STIM  in  1 each  asynchronous pin inputs, channels 0..7 in that order.
REQ-006 Port: sel  in  3  channel index to measure.
REQ-007 Port: sync_out  out  8  synchronized copy of the channels, bit i = channel i.
REQ-008 Port: rise_pulse  out  8  one-cycle pulse per channel on a synchronized rising edge.
REQ-009 Port: meas_high  out  CNT_W  high time of the selected channel, in cycles.
REQ-010 Port: meas_period  out  CNT_W  rise-to-rise period of the selected channel, in cycles.
REQ-011 Port: meas_valid  out  1  one-cycle strobe; meas_high and meas_period are updated in the same cycle.
REQ-012 Port: timeout  out  1  sticky flag; a counter saturated before the measurement completed.

Function
REQ-013 Each channel SHALL pass through SYNC_STAGES registers; sync_out[i] SHALL follow a pin change after exactly SYNC_STAGES cycles.
REQ-014 rise_pulse[i] SHALL be registered and SHALL assert one cycle after sync_out[i] goes 0->1, for exactly one cycle. No pulse on a falling edge.
REQ-015 The measurement FSM SHALL have four states: WAIT_RISE, HIGH, LOW, with IDLE as the reset state.
REQ-016 IDLE -> WAIT_RISE on the first cycle after reset deasserts.
REQ-017 WAIT_RISE -> HIGH on rise_pulse[sel]; the high and period counters SHALL load 1.
REQ-018 In HIGH, both counters SHALL increment each cycle. HIGH -> LOW on the first cycle sync_out[sel] is seen low, one cycle after the fall; the high count SHALL then freeze.
REQ-019 In LOW, the period counter SHALL increment. On rise_pulse[sel]:
  - meas_high and meas_period SHALL be updated.
  - meas_valid SHALL pulse and timeout SHALL clear.
  - both counters SHALL reload 1 and the state SHALL go to HIGH (back-to-back measurement).
REQ-020 Counters SHALL saturate at 2^CNT_W-1. On saturation in HIGH or LOW:
  - timeout SHALL set and the state SHALL go to WAIT_RISE.
  - meas_valid SHALL NOT pulse; meas_high and meas_period SHALL hold their previous values.
REQ-021 Any change of sel SHALL abort the measurement in progress and go to WAIT_RISE within one cycle, without touching meas_* or timeout. A rise_pulse in the same cycle SHALL be ignored.
REQ-022 Measured values SHALL exclude synchronizer latency. For a stable input of H cycles high and L cycles low, the values SHALL be meas_high=H and meas_period=H+L.
REQ-023 Channels SHALL be independent; rise_pulse for unselected channels SHALL continue regardless of FSM state.

Reset
REQ-024 While reset is high on a clock edge, all of the following SHALL clear to 0 on that edge:
  - all synchronizer stages, sync_out, rise_pulse;
  - meas_high, meas_period, meas_valid, timeout;
  - counters; the FSM SHALL go to IDLE.
REQ-025 Reset asserted mid-measurement SHALL discard the partial count; no meas_valid SHALL be produced for it.
REQ-026 No asynchronous reset path SHALL exist.

Structure
REQ-027 Package dffr_buffer_pkg SHALL hold:
  - the FSM state enum (IDLE, WAIT_RISE, HIGH, LOW);
  - channel index constants CH_CLK_P=0 .. CH_STIM=7;
  - NUM_CH=8.
REQ-028 Sub-module sync_edge_cell SHALL implement one channel's synchronizer chain and rise detector. It SHALL be instantiated NUM_CH times.
REQ-029 The FSM, counters and measurement registers SHALL be in the top level.

Verification
REQ-030 Reset, then channel 0 toggling 4 cycles high / 6 low, sel=0 -> meas_valid every 10 cycles with meas_high=4, meas_period=10; timeout=0.
REQ-031 Single 1-cycle high pulse on in_STIM -> rise_pulse[7] asserts for exactly 1 cycle, 4 cycles after the pin edge (3 sync stages + 1).
REQ-032 sel=2, in_clk_d held high for 70000 cycles -> timeout=1 and no meas_valid. Then toggling 5 high / 5 low -> meas_high=5, meas_period=10, timeout clears.
REQ-033 Change sel from 0 to 3 mid-HIGH -> no meas_valid for the aborted cycle; the first strobe after that reflects a full channel 3 period only.
REQ-034 Assert reset for 1 cycle during LOW -> all outputs 0 on the next cycle, FSM in IDLE, and the next valid measurement is complete and correct.
REQ-035 All 8 channels toggling at different rates, sel=5 -> rise_pulse bits match each channel's edges; meas_* reflect channel 5 only.
